// File: rtl/fft_addr_pkg.sv
// Shared types and the radix-2 DIT butterfly address mapping used by the
// FFT stage sequencer and its index-map sub-module.
package fft_addr_pkg;

    localparam int STAGE_W   = 4;
    localparam int MAX_LOG2N = 12;
    localparam int MAX_TW    = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic [31:0] top;
        logic [31:0] bottom;
        logic [31:0] tw;
    } bf_addr_t;

    // Stage 0 means "no stage" and maps to all-zero addresses so idle outputs stay quiet.
    function automatic bf_addr_t bf_map(input logic [31:0]        b,
                                        input logic [STAGE_W-1:0] s,
                                        input int                 tw_bits);
        bf_addr_t    r;
        logic [31:0] half;
        logic [31:0] k;
        logic [31:0] g;
        int          sm1;
        int          sh;
        r = '0;
        if (s != '0) begin
            sm1      = int'(s) - 1;
            half     = 32'd1 << sm1;
            k        = b & (half - 32'd1);
            g        = b >> sm1;
            r.top    = (g << s) + k;
            r.bottom = r.top + half;
            sh       = tw_bits - int'(s);
            r.tw     = k << sh;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bf_index_map.sv
// Combinational butterfly index -> top/bottom operand and twiddle address map.
module fft_bf_index_map
    import fft_addr_pkg::*;
#(
    parameter int LOG2N   = 4,
    parameter int TW_BITS = 10
) (
    input  logic [LOG2N-1:0]   b_i,
    input  logic [STAGE_W-1:0] s_i,
    output logic [LOG2N-1:0]   top_o,
    output logic [LOG2N-1:0]   bottom_o,
    output logic [TW_BITS-1:0] tw_o
);

    bf_addr_t map;

    assign map      = bf_map(32'(b_i), s_i, TW_BITS);
    assign top_o    = map.top[LOG2N-1:0];
    assign bottom_o = map.bottom[LOG2N-1:0];
    assign tw_o     = map.tw[TW_BITS-1:0];

endmodule

// File: rtl/fft_stage_seq_addr_gen.sv
// Stage-by-stage address sequencer for the in-place radix-2 DIT FFT: issues
// read triples, tracks write-back, and fences each stage on its last write.
module fft_stage_seq_addr_gen
    import fft_addr_pkg::*;
#(
    parameter int LOG2N   = 4,
    parameter int TW_BITS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               run_all,
    input  logic [3:0]         stage_sel,
    output logic [LOG2N-1:0]   rd_addr_a,
    output logic [LOG2N-1:0]   rd_addr_b,
    output logic [TW_BITS-1:0] tw_addr,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic               rd_last,
    input  logic               wr_strobe,
    output logic [LOG2N-1:0]   wr_addr_a,
    output logic [LOG2N-1:0]   wr_addr_b,
    output logic [3:0]         cur_stage,
    output logic               busy,
    output logic               stage_done,
    output logic               fft_done,
    output logic               err
);

    if (LOG2N < 1 || LOG2N > MAX_LOG2N || TW_BITS < LOG2N || TW_BITS > MAX_TW) begin : g_bad_param
        $error("fft_stage_seq_addr_gen: illegal LOG2N/TW_BITS combination");
    end

    localparam logic [LOG2N-1:0] NUM_BF = LOG2N'(1 << (LOG2N - 1));
    localparam logic [LOG2N-1:0] LAST_B = LOG2N'((1 << (LOG2N - 1)) - 1);

    state_e               state_q, state_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic                 run_all_q, run_all_d;
    logic [LOG2N-1:0]     rd_cnt_q, rd_cnt_d;
    logic [LOG2N-1:0]     wr_cnt_q, wr_cnt_d;
    logic                 err_q, err_d;

    logic                 rd_hs;
    logic                 wr_ok;
    logic                 wr_bad;
    logic                 sel_legal;
    logic [TW_BITS-1:0]   wr_tw;

    // Handshake: a triple transfers on a cycle with rd_valid & rd_ready; while
    // rd_valid is high and rd_ready low, the triple and rd_last are held and
    // rd_valid stays high until that transfer happens.
    assign rd_valid  = (state_q == ST_ISSUE);
    assign rd_last   = rd_valid && (rd_cnt_q == LAST_B);
    assign rd_hs     = rd_valid && rd_ready;

    assign wr_ok     = wr_strobe && (state_q == ST_ISSUE || state_q == ST_DRAIN)
                       && (wr_cnt_q != NUM_BF);
    assign wr_bad    = wr_strobe && !wr_ok;
    assign sel_legal = (stage_sel != 4'd0) && (int'(stage_sel) <= LOG2N);

    assign cur_stage  = stage_q;
    assign busy       = (state_q != ST_IDLE);
    assign stage_done = (state_q == ST_NEXT);
    assign fft_done   = (state_q == ST_DONE);
    assign err        = err_q;

    fft_bf_index_map #(
        .LOG2N   (LOG2N),
        .TW_BITS (TW_BITS)
    ) u_rd_map (
        .b_i      (rd_cnt_q),
        .s_i      (stage_q),
        .top_o    (rd_addr_a),
        .bottom_o (rd_addr_b),
        .tw_o     (tw_addr)
    );

    fft_bf_index_map #(
        .LOG2N   (LOG2N),
        .TW_BITS (TW_BITS)
    ) u_wr_map (
        .b_i      (wr_cnt_q),
        .s_i      (stage_q),
        .top_o    (wr_addr_a),
        .bottom_o (wr_addr_b),
        .tw_o     (wr_tw)
    );

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        run_all_d = run_all_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (run_all || sel_legal) begin
                        run_all_d = run_all;
                        stage_d   = run_all ? STAGE_W'(1) : stage_sel;
                        rd_cnt_d  = '0;
                        wr_cnt_d  = '0;
                        err_d     = 1'b0;
                        state_d   = ST_ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (rd_hs) begin
                    rd_cnt_d = rd_cnt_q + LOG2N'(1);
                    if (rd_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Fence: the next stage reads only after every write has landed.
                if (wr_cnt_q == NUM_BF) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (run_all_q && (int'(stage_q) < LOG2N)) begin
                    stage_d  = stage_q + STAGE_W'(1);
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                stage_d   = '0;
                run_all_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_ok) begin
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
        end
        if (wr_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            stage_q   <= '0;
            run_all_q <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            run_all_q <= run_all_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_fft_stage_seq_addr_gen.sv
// Bench for fft_stage_seq_addr_gen: arithmetic address model, per-cycle
// compare process, and directed jobs covering modes, stalls, errors and reset.
module tb_fft_stage_seq_addr_gen;

    localparam int LOG2N   = 4;
    localparam int TW_BITS = 10;
    localparam int NB      = 8;
    localparam int RW      = 23;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               run_all = 1'b0;
    logic [3:0]         stage_sel = 4'd0;
    logic               rd_ready = 1'b0;
    logic               wr_strobe = 1'b0;
    logic [LOG2N-1:0]   rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [TW_BITS-1:0] tw_addr;
    logic               rd_valid, rd_last, busy, stage_done, fft_done, err;
    logic [3:0]         cur_stage;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int sd_cnt = 0;
    int fd_cnt = 0;
    int last_rdlast_cyc = -100;
    int gap_exp = 0;
    logic in_reset = 1'b1;
    logic prev_stall = 1'b0;
    logic prev_sd = 1'b0;
    logic [23:0] held = '0;

    logic [RW-1:0] exp_q[$];
    logic [7:0]    wexp_q[$];
    int            due_q[$];

    always #5 clk = ~clk;

    fft_stage_seq_addr_gen #(
        .LOG2N   (LOG2N),
        .TW_BITS (TW_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .run_all    (run_all),
        .stage_sel  (stage_sel),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .tw_addr    (tw_addr),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_last    (rd_last),
        .wr_strobe  (wr_strobe),
        .wr_addr_a  (wr_addr_a),
        .wr_addr_b  (wr_addr_b),
        .cur_stage  (cur_stage),
        .busy       (busy),
        .stage_done (stage_done),
        .fft_done   (fft_done),
        .err        (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event did not occur as expected (t=%0t)", name, $time);
    endtask

    // Expected {stage, last, top, bottom, tw} for butterfly b of stage s, from plain arithmetic.
    function automatic logic [RW-1:0] model_rd(input int b, input int s);
        int half, top, bot, tw;
        half = 1 << (s - 1);
        top  = (b / half) * (2 * half) + (b % half);
        bot  = top + half;
        tw   = (b % half) * ((1 << TW_BITS) / (2 * half));
        return {4'(s), (b == NB - 1), 4'(top), 4'(bot), 10'(tw)};
    endfunction

    always @(negedge clk) begin
        logic [RW-1:0] e;
        #2;
        cyc++;
        if (!in_reset) begin
            if (prev_stall)
                check("stall_hold", {rd_valid, cur_stage, rd_last, rd_addr_a, rd_addr_b, tw_addr}, held);
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    fail("rd_extra");
                end else begin
                    e = exp_q.pop_front();
                    check("rd_triple", {cur_stage, rd_last, rd_addr_a, rd_addr_b, tw_addr}, e);
                    if (e[17:14] == 4'd0)
                        check("stage_fence", wexp_q.size(), 0);
                    wexp_q.push_back(e[17:10]);
                    if (rd_last) last_rdlast_cyc = cyc;
                end
            end
            if (wr_strobe && wexp_q.size() > 0)
                check("wr_addr", {wr_addr_a, wr_addr_b}, wexp_q.pop_front());
            if (stage_done) begin
                sd_cnt++;
                if (gap_exp > 0) check("stage_done_gap", cyc - last_rdlast_cyc, gap_exp);
            end
            if (fft_done) begin
                fd_cnt++;
                check("fft_after_stage", prev_sd, 1);
            end
            prev_stall = rd_valid && !rd_ready;
            held       = {rd_valid, cur_stage, rd_last, rd_addr_a, rd_addr_b, tw_addr};
            prev_sd    = stage_done;
        end else begin
            prev_stall = 1'b0;
            prev_sd    = 1'b0;
        end
    end

    task automatic do_reset();
        #1;
        in_reset = 1'b1;
        rst_n = 1'b0;
        start = 1'b0;
        rd_ready = 1'b0;
        wr_strobe = 1'b0;
        #1;
        check("rst_async_rd", {rd_valid, rd_last, rd_addr_a, rd_addr_b, tw_addr}, 0);
        check("rst_async_ctl", {wr_addr_a, wr_addr_b, cur_stage, busy, stage_done, fft_done, err}, 0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold", {stage_done, fft_done, busy, rd_valid, cur_stage}, 0);
        end
        rst_n = 1'b1;
        exp_q.delete();
        wexp_q.delete();
        due_q.delete();
        in_reset = 1'b0;
    endtask

    task automatic illegal_start(input logic [3:0] sel);
        @(negedge clk);
        start = 1'b1;
        run_all = 1'b0;
        stage_sel = sel;
        @(negedge clk);
        start = 1'b0;
        stage_sel = 4'd0;
        check("illegal_err", err, 1);
        check("illegal_idle", {busy, rd_valid, cur_stage}, 0);
    endtask

    task automatic run_job(input logic ra, input logic [3:0] sel, input int delay,
                           input logic stalls, input logic extra_wr, input int abort_stage);
        int   first_s, last_s, sd0, fd0, dc, abort_cnt;
        logic hs, done, aborted, extra_pend, err_pend;
        first_s = ra ? 1 : int'(sel);
        last_s  = ra ? LOG2N : int'(sel);
        for (int s = first_s; s <= last_s; s++)
            for (int b = 0; b < NB; b++)
                exp_q.push_back(model_rd(b, s));
        due_q.delete();
        sd0 = sd_cnt; fd0 = fd_cnt; gap_exp = delay + 2;
        dc = 0; abort_cnt = 0; done = 0; aborted = 0; extra_pend = 0; err_pend = 0;
        @(negedge clk);
        start = 1'b1;
        run_all = ra;
        stage_sel = sel;
        @(negedge clk);
        start = 1'b0;
        run_all = 1'b0;
        stage_sel = 4'd0;
        check("start_latency", {busy, rd_valid}, 2'b11);
        check("start_err_clr", err, 0);
        check("start_stage", cur_stage, first_s);
        for (int i = 0; i < 2000 && !done; i++) begin
            if (i > 0) @(negedge clk);
            if (err_pend) begin
                check("err_extra_wr", err, 1);
                err_pend = 0;
            end
            if (fd_cnt != fd0) begin
                done = 1;
                rd_ready = 1'b0;
                wr_strobe = 1'b0;
                check("busy_off", busy, 0);
            end else if (abort_stage != 0 && abort_cnt >= 4) begin
                do_reset();
                done = 1;
                aborted = 1;
            end else begin
                if (abort_stage != 0 && int'(cur_stage) == abort_stage) abort_cnt++;
                rd_ready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
                hs = rd_valid && rd_ready;
                if (hs) due_q.push_back(dc + delay);
                wr_strobe = 1'b0;
                if (due_q.size() > 0 && due_q[0] == dc) begin
                    void'(due_q.pop_front());
                    wr_strobe = 1'b1;
                end
                if (extra_pend) begin
                    wr_strobe = 1'b1;
                    extra_pend = 0;
                    err_pend = 1;
                end
                if (extra_wr && hs && rd_last) extra_pend = 1;
                dc++;
            end
        end
        if (!done) begin
            fail("job_timeout");
        end else if (!aborted) begin
            check("stage_done_count", sd_cnt - sd0, last_s - first_s + 1);
            check("fft_done_count", fd_cnt - fd0, 1);
            check("reads_consumed", exp_q.size(), 0);
            check("writes_consumed", wexp_q.size(), 0);
        end
        rd_ready = 1'b0;
        wr_strobe = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_rd", {rd_valid, rd_last, rd_addr_a, rd_addr_b, tw_addr}, 0);
        check("reset_ctl", {wr_addr_a, wr_addr_b, cur_stage, busy, stage_done, fft_done, err}, 0);

        check("pin_s2_b1", model_rd(1, 2), {4'd2, 1'b0, 4'd1, 4'd3, 10'd256});
        check("pin_s2_b2", model_rd(2, 2), {4'd2, 1'b0, 4'd4, 4'd6, 10'd0});
        check("pin_s2_b7", model_rd(7, 2), {4'd2, 1'b1, 4'd13, 4'd15, 10'd256});
        check("pin_s4_b1", model_rd(1, 4), {4'd4, 1'b0, 4'd1, 4'd9, 10'd64});
        check("pin_s4_b7", model_rd(7, 4), {4'd4, 1'b1, 4'd7, 4'd15, 10'd448});
        check("pin_s1_b7", model_rd(7, 1), {4'd1, 1'b1, 4'd14, 4'd15, 10'd0});
        check("pin_s3_b3", model_rd(3, 3), {4'd3, 1'b0, 4'd3, 4'd7, 10'd384});

        rst_n = 1'b1;
        in_reset = 1'b0;
        @(negedge clk);

        run_job(1'b0, 4'd2, 0, 1'b0, 1'b0, 0);
        run_job(1'b0, 4'd4, 1, 1'b0, 1'b0, 0);
        run_job(1'b0, 4'd1, 0, 1'b0, 1'b1, 0);
        run_job(1'b1, 4'd0, 3, 1'b1, 1'b0, 0);

        illegal_start(4'd0);
        run_job(1'b0, 4'd3, 0, 1'b1, 1'b0, 0);
        illegal_start(4'd5);

        run_job(1'b1, 4'd0, 1, 1'b0, 1'b0, 3);
        run_job(1'b1, 4'd0, 0, 1'b0, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
